// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M stage: single-cycle posted stores, multi-cycle
// stalled loads, byte/half lane handling with sign/zero extension and alignment checks.
module dmem_responder #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic [AW+1:0]   cap_addr;
  logic [1:0]      cap_size;
  logic            cap_signed;
  logic            misaligned, load_go, store_go, load_done;
  logic [AW+1:0]   rd_addr;
  logic [1:0]      rd_size;
  logic            rd_signed;
  logic [31:0]     rd_word;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic            unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign unused_addr_bits = ^aluoutM[31:AW+2];

  // Extracts the addressed lane(s) from a little-endian word and extends to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] lane,
                                         input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (sizeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = aluoutM[0];
      default: misaligned = (aluoutM[1:0] != 2'b00);
    endcase
  end

  assign adelM = memenM & ~memwriteM & misaligned;
  assign adesM = memenM &  memwriteM & misaligned;

  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stallM     = 1'b0;
    load_go    = 1'b0;
    store_go   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (memenM && !misaligned) begin
          if (memwriteM) begin
            store_go = 1'b1;
          end else begin
            load_go = 1'b1;
            stallM  = 1'b1;
            if (RD_LAT == 1) begin
              state_next = RESP;
              load_done  = 1'b1;
            end else begin
              // The acceptance cycle already counts as one stall cycle.
              state_next = BUSY;
              cnt_next   = 4'(RD_LAT - 2);
            end
          end
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (cnt == 4'd0) begin
          state_next = RESP;
          load_done  = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With single-cycle latency the read happens in the acceptance cycle, before capture.
  always_comb begin
    if (state == IDLE) begin
      rd_addr   = aluoutM[AW+1:0];
      rd_size   = sizeM;
      rd_signed = signedM;
    end else begin
      rd_addr   = cap_addr;
      rd_size   = cap_size;
      rd_signed = cap_signed;
    end
  end

  assign rd_word = mem[rd_addr[AW+1:2]];

  always_comb begin
    case (sizeM)
      2'b00: begin
        be    = 4'b0001 << aluoutM[1:0];
        wlane = {4{writedataM[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << aluoutM[1:0];
        wlane = {2{writedataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = writedataM;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      readdataM <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_go) begin
        cap_addr   <= aluoutM[AW+1:0];
        cap_size   <= sizeM;
        cap_signed <= signedM;
      end
      if (load_done) readdataM <= extend(rd_word, rd_addr[1:0], rd_size, rd_signed);
    end
  end

  // NOTE: the word array has no reset; its contents survive rst and start undefined.
  always_ff @(posedge clk) begin
    if (!rst && store_go) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[aluoutM[AW+1:2]][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: three instances (load latency 2, 1, 15) checked
// against a byte-array reference model of the memory and of the load/store rules.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        memen [3];
  logic        wr    [3];
  logic [1:0]  size  [3];
  logic        sgn   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        adel  [3];
  logic        ades  [3];

  int          lat [3] = '{2, 1, 15};
  logic [7:0]  mb [3][256];
  logic [31:0] prev_rd [3];
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_responder #(.DEPTH(1024), .RD_LAT(2)) dut0 (
    .clk(clk), .rst(rst[0]), .memenM(memen[0]), .memwriteM(wr[0]), .sizeM(size[0]),
    .signedM(sgn[0]), .aluoutM(addr[0]), .writedataM(wdata[0]), .readdataM(rdata[0]),
    .stallM(stall[0]), .adelM(adel[0]), .adesM(ades[0]));
  dmem_responder #(.DEPTH(1024), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst[1]), .memenM(memen[1]), .memwriteM(wr[1]), .sizeM(size[1]),
    .signedM(sgn[1]), .aluoutM(addr[1]), .writedataM(wdata[1]), .readdataM(rdata[1]),
    .stallM(stall[1]), .adelM(adel[1]), .adesM(ades[1]));
  dmem_responder #(.DEPTH(1024), .RD_LAT(15)) dut2 (
    .clk(clk), .rst(rst[2]), .memenM(memen[2]), .memwriteM(wr[2]), .sizeM(size[2]),
    .signedM(sgn[2]), .aluoutM(addr[2]), .writedataM(wdata[2]), .readdataM(rdata[2]),
    .stallM(stall[2]), .adelM(adel[2]), .adesM(ades[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] s);
    return (nbytes(s) == 2) ? a[0] : (nbytes(s) == 4) ? (a[1:0] != 2'b00) : 1'b0;
  endfunction

  // Reference load value: gather bytes from the model, then extend arithmetically.
  function automatic logic [31:0] model_load(input int i, input logic [31:0] a,
                                             input logic [1:0] s, input logic sg);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[i][(a + k) & 255]) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic do_store(input int i, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d);
    logic mis;
    @(negedge clk);
    memen[i] = 1'b1; wr[i] = 1'b1; size[i] = s; sgn[i] = 1'b0; addr[i] = a; wdata[i] = d;
    #1;
    mis = is_mis(a, s);
    check("ades", 32'(ades[i]), 32'(mis));
    check("adel_on_store", 32'(adel[i]), 32'd0);
    check("stall_on_store", 32'(stall[i]), 32'd0);
    if (!mis) for (int k = 0; k < nbytes(s); k++) mb[i][(a + k) & 255] = d[8*k +: 8];
  endtask

  task automatic do_load(input int i, input logic [31:0] a, input logic [1:0] s,
                         input logic sg);
    logic mis;
    int n;
    @(negedge clk);
    memen[i] = 1'b1; wr[i] = 1'b0; size[i] = s; sgn[i] = sg; addr[i] = a; wdata[i] = $urandom;
    #1;
    mis = is_mis(a, s);
    check("adel", 32'(adel[i]), 32'(mis));
    check("ades_on_load", 32'(ades[i]), 32'd0);
    if (mis) begin
      check("stall_misaligned", 32'(stall[i]), 32'd0);
      @(negedge clk); #1;
      check("rd_unchanged", rdata[i], prev_rd[i]);
      check("stall_misaligned_next", 32'(stall[i]), 32'd0);
    end else begin
      n = 0;
      while (stall[i] && n < 40) begin
        n++;
        @(negedge clk); #1;
      end
      check($sformatf("stall_len_lat%0d", lat[i]), 32'(n), 32'(lat[i]));
      prev_rd[i] = model_load(i, a, s, sg);
      check("load_data", rdata[i], prev_rd[i]);
    end
  endtask

  task automatic idle_cycle(input int i);
    @(negedge clk);
    memen[i] = 1'b0; wr[i] = $urandom_range(0, 1); size[i] = 2'b10; addr[i] = 32'h3;
    #1;
    check("adel_gated", 32'(adel[i]), 32'd0);
    check("ades_gated", 32'(ades[i]), 32'd0);
    check("stall_idle", 32'(stall[i]), 32'd0);
  endtask

  task automatic random_ops(input int i, input int count);
    logic [31:0] a;
    for (int t = 0; t < count; t++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0, 1:    do_store(i, a, 2'($urandom_range(0, 3)), $urandom);
        2, 3:    do_load(i, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        default: idle_cycle(i);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; memen[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'b10; sgn[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0; prev_rd[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_rd", rdata[i], 32'h0);
      check("reset_stall", 32'(stall[i]), 32'd0);
      check("reset_adel", 32'(adel[i]), 32'd0);
      check("reset_ades", 32'(ades[i]), 32'd0);
    end

    // Give every model byte a defined value before any load.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++) do_store(i, 32'(w * 4), 2'b10, $urandom);

    // Directed scenarios on the latency-2 instance.
    do_store(0, 32'h40, 2'b10, 32'hDEADBEEF);
    do_load(0, 32'h40, 2'b10, 1'b0);
    check("word_rt_const", rdata[0], 32'hDEADBEEF);
    do_store(0, 32'h41, 2'b00, 32'h12);
    do_load(0, 32'h40, 2'b10, 1'b0);
    check("byte_store_const", rdata[0], 32'hDEAD12EF);
    do_load(0, 32'h43, 2'b00, 1'b1);
    check("lb_signed_const", rdata[0], 32'hFFFFFFDE);
    do_load(0, 32'h43, 2'b00, 1'b0);
    check("lbu_const", rdata[0], 32'h000000DE);
    do_load(0, 32'h42, 2'b01, 1'b1);
    check("lh_signed_const", rdata[0], 32'hFFFFDEAD);
    do_load(0, 32'h42, 2'b10, 1'b0);
    check("misaligned_rd_const", rdata[0], 32'hFFFFDEAD);
    do_store(0, 32'h44, 2'b10, 32'h01234567);
    do_store(0, 32'h45, 2'b01, 32'hAAAA);
    do_load(0, 32'h44, 2'b10, 1'b0);
    check("mis_store_no_write", rdata[0], 32'h01234567);
    do_store(0, 32'h1000, 2'b10, 32'hCAFEF00D);
    do_load(0, 32'h0000, 2'b10, 1'b0);
    check("wrap_alias", rdata[0], 32'hCAFEF00D);
    do_load(0, 32'h44, 2'b10, 1'b0);
    check("back_to_back", rdata[0], 32'h01234567);

    // Reset during BUSY: stall drops, result cleared, array contents survive.
    @(negedge clk);
    memen[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'b10; addr[0] = 32'h40;
    @(negedge clk); #1;
    check("busy_stall", 32'(stall[0]), 32'd1);
    rst[0] = 1'b1; memen[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall[0]), 32'd0);
    check("rst_mid_rd", rdata[0], 32'h0);
    prev_rd[0] = 32'h0;
    do_load(0, 32'h1000, 2'b10, 1'b0);
    check("survives_reset", rdata[0], 32'hCAFEF00D);

    for (int i = 0; i < 3; i++) random_ops(i, 150);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
